// File: rtl/mux_data_gen_pkg.sv
// rtl/mux_data_gen_pkg.sv - shared constants and beat type for the I2C harness stream demux
package mux_data_gen_pkg;
    localparam int NUM_PORTS = 5;
    localparam int DATA_W    = 8;

    localparam logic [2:0] PORT_M1 = 3'd0;
    localparam logic [2:0] PORT_M2 = 3'd1;
    localparam logic [2:0] PORT_S1 = 3'd2;
    localparam logic [2:0] PORT_S2 = 3'd3;
    localparam logic [2:0] PORT_S3 = 3'd4;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [2:0]        dest;
    } beat_t;
endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - output register plus one-entry skid, beats carry their own dest tag
module axis_skid_buffer
    import mux_data_gen_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_accept,
    input  beat_t i_beat,
    input  logic  i_dready,
    output beat_t o_beat,
    output logic  o_ov,
    output logic  o_sv
);
    beat_t r_out;
    beat_t r_skid;
    logic  r_ov;
    logic  r_sv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out  <= '0;
            r_skid <= '0;
            r_ov   <= 1'b0;
            r_sv   <= 1'b0;
        end else if (!r_ov || i_dready) begin
            // Skid always drains first so beat order is preserved.
            if (r_sv) begin
                r_out <= r_skid;
                r_ov  <= 1'b1;
                r_sv  <= 1'b0;
            end else if (i_accept) begin
                r_out <= i_beat;
                r_ov  <= 1'b1;
            end else begin
                r_ov  <= 1'b0;
            end
        end else if (i_accept) begin
            r_skid <= i_beat;
            r_sv   <= 1'b1;
        end
    end

    assign o_beat = r_out;
    assign o_ov   = r_ov;
    assign o_sv   = r_sv;
endmodule

// File: rtl/mux_data_gen.sv
// rtl/mux_data_gen.sv - registered 1-to-5 stream demux with per-packet route lock
module mux_data_gen
    import mux_data_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        sel,
    input  logic [DATA_W-1:0] tdata,
    input  logic              tvalid,
    input  logic              tlast,
    output logic              tready,
    input  logic              tready_m1,
    input  logic              tready_m2,
    input  logic              tready_s1,
    input  logic              tready_s2,
    input  logic              tready_s3,
    output logic [DATA_W-1:0] tdata_m1,
    output logic [DATA_W-1:0] tdata_m2,
    output logic [DATA_W-1:0] tdata_s1,
    output logic [DATA_W-1:0] tdata_s2,
    output logic [DATA_W-1:0] tdata_s3,
    output logic              tvalid_m1,
    output logic              tvalid_m2,
    output logic              tvalid_s1,
    output logic              tvalid_s2,
    output logic              tvalid_s3,
    output logic              tlast_m1,
    output logic              tlast_m2,
    output logic              tlast_s1,
    output logic              tlast_s2,
    output logic              tlast_s3
);
    logic       r_in_pkt;
    logic [2:0] r_route;
    logic [2:0] w_route;
    logic       w_accept;
    logic       w_ov;
    logic       w_sv;
    logic       w_dready;
    beat_t      w_in;
    beat_t      w_out;

    assign w_route  = r_in_pkt ? r_route : sel;
    assign tready   = !rst && !w_sv && (r_in_pkt || (sel < 3'(NUM_PORTS)));
    assign w_accept = tvalid && tready;
    assign w_in     = '{data: tdata, last: tlast, dest: w_route};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_pkt <= 1'b0;
            r_route  <= 3'd0;
        end else if (w_accept) begin
            r_in_pkt <= !tlast;
            if (!r_in_pkt)
                r_route <= sel;
        end
    end

    axis_skid_buffer u_skid (
        .clk      (clk),
        .rst      (rst),
        .i_accept (w_accept),
        .i_beat   (w_in),
        .i_dready (w_dready),
        .o_beat   (w_out),
        .o_ov     (w_ov),
        .o_sv     (w_sv)
    );

    // Only the port named by the held beat's dest sees anything; others read zero.
    always_comb begin
        w_dready  = 1'b0;
        tvalid_m1 = 1'b0; tdata_m1 = '0; tlast_m1 = 1'b0;
        tvalid_m2 = 1'b0; tdata_m2 = '0; tlast_m2 = 1'b0;
        tvalid_s1 = 1'b0; tdata_s1 = '0; tlast_s1 = 1'b0;
        tvalid_s2 = 1'b0; tdata_s2 = '0; tlast_s2 = 1'b0;
        tvalid_s3 = 1'b0; tdata_s3 = '0; tlast_s3 = 1'b0;
        case (w_out.dest)
            PORT_M1: begin
                w_dready = tready_m1;
                tvalid_m1 = w_ov; tdata_m1 = w_out.data; tlast_m1 = w_out.last;
            end
            PORT_M2: begin
                w_dready = tready_m2;
                tvalid_m2 = w_ov; tdata_m2 = w_out.data; tlast_m2 = w_out.last;
            end
            PORT_S1: begin
                w_dready = tready_s1;
                tvalid_s1 = w_ov; tdata_s1 = w_out.data; tlast_s1 = w_out.last;
            end
            PORT_S2: begin
                w_dready = tready_s2;
                tvalid_s2 = w_ov; tdata_s2 = w_out.data; tlast_s2 = w_out.last;
            end
            PORT_S3: begin
                w_dready = tready_s3;
                tvalid_s3 = w_ov; tdata_s3 = w_out.data; tlast_s3 = w_out.last;
            end
            default: w_dready = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_mux_data_gen.sv
// tb/tb_mux_data_gen.sv - directed self-checking bench for mux_data_gen
module tb_mux_data_gen;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] sel;
    logic [7:0] tdata;
    logic       tvalid, tlast, tready;
    logic       tready_m1, tready_m2, tready_s1, tready_s2, tready_s3;
    logic [7:0] tdata_m1, tdata_m2, tdata_s1, tdata_s2, tdata_s3;
    logic       tvalid_m1, tvalid_m2, tvalid_s1, tvalid_s2, tvalid_s3;
    logic       tlast_m1, tlast_m2, tlast_s1, tlast_s2, tlast_s3;

    int checks = 0;
    int failures = 0;

    logic [4:0] valids;
    logic [4:0] lasts;
    logic [7:0] data_or;
    assign valids  = {tvalid_s3, tvalid_s2, tvalid_s1, tvalid_m2, tvalid_m1};
    assign lasts   = {tlast_s3, tlast_s2, tlast_s1, tlast_m2, tlast_m1};
    assign data_or = tdata_m1 | tdata_m2 | tdata_s1 | tdata_s2 | tdata_s3;

    mux_data_gen dut (
        .clk(clk), .rst(rst), .sel(sel), .tdata(tdata), .tvalid(tvalid),
        .tlast(tlast), .tready(tready),
        .tready_m1(tready_m1), .tready_m2(tready_m2), .tready_s1(tready_s1),
        .tready_s2(tready_s2), .tready_s3(tready_s3),
        .tdata_m1(tdata_m1), .tdata_m2(tdata_m2), .tdata_s1(tdata_s1),
        .tdata_s2(tdata_s2), .tdata_s3(tdata_s3),
        .tvalid_m1(tvalid_m1), .tvalid_m2(tvalid_m2), .tvalid_s1(tvalid_s1),
        .tvalid_s2(tvalid_s2), .tvalid_s3(tvalid_s3),
        .tlast_m1(tlast_m1), .tlast_m2(tlast_m2), .tlast_s1(tlast_s1),
        .tlast_s2(tlast_s2), .tlast_s3(tlast_s3)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Backpressure table: inputs before each edge and expected s2 output/tready after it.
    logic [7:0] bp_in   [11] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h04, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    logic       bp_rdy  [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0] bp_out  [11] = '{8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    logic       bp_trdy [11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        rst = 1'b1; sel = 3'd0; tdata = 8'h55; tvalid = 1'b1; tlast = 1'b0;
        tready_m1 = 1'b1; tready_m2 = 1'b1; tready_s1 = 1'b1; tready_s2 = 1'b1; tready_s3 = 1'b1;

        // Reset held two cycles with tvalid high
        tick;
        tick;
        chk("rst_valids", 32'(valids), 32'h0);
        chk("rst_data", 32'(data_or), 32'h0);
        chk("rst_lasts", 32'(lasts), 32'h0);
        chk("rst_tready", 32'(tready), 32'h0);
        rst = 1'b0; tvalid = 1'b0; #1;
        chk("post_rst_tready", 32'(tready), 32'h1);

        // Basic routing to s1
        sel = 3'd2; tdata = 8'hA5; tlast = 1'b1; tvalid = 1'b1;
        tick;
        tvalid = 1'b0; #1;
        chk("basic_valids", 32'(valids), 32'b00100);
        chk("basic_data", 32'(tdata_s1), 32'hA5);
        chk("basic_last", 32'(tlast_s1), 32'h1);
        tick;
        chk("basic_drain", 32'(valids), 32'h0);

        // Route lock: sel moves to 4 mid-packet
        sel = 3'd0; tdata = 8'h11; tlast = 1'b0; tvalid = 1'b1;
        tick;
        sel = 3'd4; tdata = 8'h22; #1;
        chk("lock_b0_valids", 32'(valids), 32'b00001);
        chk("lock_b0_data", 32'(tdata_m1), 32'h11);
        chk("lock_tready", 32'(tready), 32'h1);
        tick;
        tdata = 8'h33; tlast = 1'b1; #1;
        chk("lock_b1_data", 32'(tdata_m1), 32'h22);
        chk("lock_b1_valids", 32'(valids), 32'b00001);
        tick;
        tdata = 8'h44; tlast = 1'b1; #1;
        chk("lock_b2_data", 32'(tdata_m1), 32'h33);
        chk("lock_b2_last", 32'(tlast_m1), 32'h1);
        tick;
        tvalid = 1'b0; #1;
        chk("next_pkt_valids", 32'(valids), 32'b10000);
        chk("next_pkt_data", 32'(tdata_s3), 32'h44);
        tick;

        // Backpressure on s2, three stalled cycles
        sel = 3'd3;
        for (int i = 0; i < 11; i++) begin
            tdata = bp_in[i]; tvalid = 1'b1; tlast = (i == 10); tready_s2 = bp_rdy[i];
            tick;
            chk($sformatf("bp_data_%0d", i), 32'(tdata_s2), 32'(bp_out[i]));
            chk($sformatf("bp_valid_%0d", i), 32'(valids), 32'b01000);
            chk($sformatf("bp_tready_%0d", i), 32'(tready), 32'(bp_trdy[i]));
        end
        chk("bp_last", 32'(tlast_s2), 32'h1);
        tvalid = 1'b0; tlast = 1'b0;
        tick;
        chk("bp_drain", 32'(valids), 32'h0);

        // Invalid select stalls without dropping
        sel = 3'd6; tdata = 8'h9C; tlast = 1'b1; tvalid = 1'b1; #1;
        chk("inv_tready", 32'(tready), 32'h0);
        tick;
        chk("inv_valids_a", 32'(valids), 32'h0);
        tick;
        chk("inv_valids_b", 32'(valids), 32'h0);
        chk("inv_tready_b", 32'(tready), 32'h0);
        sel = 3'd1; #1;
        chk("inv_fix_tready", 32'(tready), 32'h1);
        tick;
        tvalid = 1'b0; #1;
        chk("inv_fix_valids", 32'(valids), 32'b00010);
        chk("inv_fix_data", 32'(tdata_m2), 32'h9C);
        tick;

        // Cross-packet drain: 7E held on m1, 5A for m2 waits behind it
        sel = 3'd0; tdata = 8'h7E; tlast = 1'b1; tvalid = 1'b1; tready_m1 = 1'b0;
        tick;
        sel = 3'd1; tdata = 8'h5A; #1;
        chk("x_m1_valids", 32'(valids), 32'b00001);
        chk("x_m1_data", 32'(tdata_m1), 32'h7E);
        chk("x_tready", 32'(tready), 32'h1);
        tick;
        tvalid = 1'b0; #1;
        chk("x_hold_valids", 32'(valids), 32'b00001);
        chk("x_hold_data", 32'(tdata_m1), 32'h7E);
        chk("x_skid_tready", 32'(tready), 32'h0);
        tick;
        chk("x_hold2_valids", 32'(valids), 32'b00001);
        tready_m1 = 1'b1;
        tick;
        chk("x_m2_valids", 32'(valids), 32'b00010);
        chk("x_m2_data", 32'(tdata_m2), 32'h5A);
        chk("x_m1_cleared", 32'(tdata_m1), 32'h0);
        tick;
        chk("x_drain", 32'(valids), 32'h0);

        // Reset mid-packet with a full skid
        sel = 3'd3; tdata = 8'h66; tlast = 1'b0; tvalid = 1'b1; tready_s2 = 1'b0;
        tick;
        tdata = 8'h67;
        tick;
        rst = 1'b1;
        tick;
        chk("mid_rst_valids", 32'(valids), 32'h0);
        chk("mid_rst_tready", 32'(tready), 32'h0);
        rst = 1'b0; sel = 3'd5; #1;
        chk("unlock_sel5_tready", 32'(tready), 32'h0);
        sel = 3'd2; tdata = 8'h77; tlast = 1'b1; tready_s2 = 1'b1;
        tick;
        tvalid = 1'b0; #1;
        chk("unlock_valids", 32'(valids), 32'b00100);
        chk("unlock_data", 32'(tdata_s1), 32'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
